fft_bitrev_buffer: RTL

- Output reorder stage sitting directly downstream of the last butterfly in the pipelined radix-2 FFT chain.
- The butterfly chain emits each N = 2^LOG_N point frame in bit-reversed order; this block converts it to natural order.
- Uses a ping-pong pair of N-entry complex memories: it writes one frame in arrival order and reads the other in bit-reversed address order.
- Continuous stream, one sample per clock, frames delimited by a sync pulse (same stream convention as the butterfly stages).

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_bitrev_buffer_dp_ram.sv | 35 +++
 rtl/fft_bitrev_buffer.sv | 115 +++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder stage.
package fft_pkg;

    localparam int MAX_LOG_N = 12;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        FILL,
        STREAM
    } state_t;

    // Reverse the low 'width' bits of x; higher result bits are zero.
    function automatic logic [MAX_LOG_N-1:0] bitrev(
        input logic [MAX_LOG_N-1:0] x,
        input int                   width
    );
        logic [MAX_LOG_N-1:0] r;
        r = {<<{x}};
        return r >> (MAX_LOG_N - width);
    endfunction

endpackage

// File: rtl/fft_bitrev_buffer_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register clears when no read is issued, so it doubles as the zeroed output stage.
module dp_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 66
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/fft_bitrev_buffer.sv
// Converts a bit-reversed FFT frame stream to natural order via ping-pong banks.
// Constant latency N+1 cycles from input sample 0 to output sample 0.
module fft_bitrev_buffer
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 33,
    parameter int LOG_N      = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sink_sync,
    input  logic signed [DATA_WIDTH-1:0] sink_Re,
    input  logic signed [DATA_WIDTH-1:0] sink_Im,
    output logic                         source_sync,
    output logic                         source_valid,
    output logic signed [DATA_WIDTH-1:0] source_Re,
    output logic signed [DATA_WIDTH-1:0] source_Im
);

    localparam int               N    = 2**LOG_N;
    localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);
    localparam logic [LOG_N-1:0] ONE  = LOG_N'(1);

    state_t                  state, state_nxt;
    logic [LOG_N-1:0]        wr_cnt, wr_cnt_nxt, wr_idx;
    logic [LOG_N-1:0]        rd_cnt, rd_idx;
    logic                    wr_bank, wr_en, frame_done, rd_active;
    logic [2*DATA_WIDTH-1:0] rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // A sync always writes index 0; in running states it discards any partial frame.
    always_comb begin
        state_nxt  = state;
        wr_en      = 1'b0;
        wr_idx     = '0;
        wr_cnt_nxt = wr_cnt;
        frame_done = 1'b0;
        case (state)
            WAIT_SYNC: begin
                if (sink_sync) begin
                    wr_en      = 1'b1;
                    wr_cnt_nxt = ONE;
                    state_nxt  = FILL;
                end
            end
            FILL, STREAM: begin
                wr_en = 1'b1;
                if (sink_sync) begin
                    wr_cnt_nxt = ONE;
                end else begin
                    wr_idx     = wr_cnt;
                    wr_cnt_nxt = wr_cnt + ONE;
                    if (wr_cnt == LAST) begin
                        frame_done = 1'b1;
                        state_nxt  = STREAM;
                    end
                end
            end
            default: state_nxt = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt       <= '0;
            wr_bank      <= 1'b0;
            rd_cnt       <= '0;
            rd_active    <= 1'b0;
            source_valid <= 1'b0;
            source_sync  <= 1'b0;
        end else begin
            wr_cnt       <= wr_cnt_nxt;
            source_valid <= rd_active;
            source_sync  <= rd_active && (rd_cnt == '0);
            if (frame_done) begin
                wr_bank   <= ~wr_bank;
                rd_cnt    <= '0;
                rd_active <= 1'b1;
            end else if (rd_active) begin
                rd_cnt <= rd_cnt + ONE;
                if (rd_cnt == LAST) begin
                    rd_active <= 1'b0;
                end
            end
        end
    end

    // The read side always works on the bank not currently being written.
    assign rd_idx = LOG_N'(bitrev(MAX_LOG_N'(rd_cnt), LOG_N));

    dp_ram #(
        .ADDR_WIDTH(LOG_N + 1),
        .WIDTH     (2 * DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr({wr_bank, wr_idx}),
        .wr_data({sink_Re, sink_Im}),
        .rd_en  (rd_active),
        .rd_addr({~wr_bank, rd_idx}),
        .rd_data(rd_data)
    );

    assign source_Re = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign source_Im = rd_data[DATA_WIDTH-1:0];

endmodule
